// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the phase-1 datapath strobes.
// Define ILLEGAL_TRAP_EN to make undefined opcodes set the sticky illegal flag and halt.
module control_sequencer #(
   parameter logic [4:0] NOP_OPC  = 5'b11000,
   parameter logic [4:0] HALT_OPC = 5'b11001,
   parameter int         REG_W    = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Stop,
   input  logic [31:0]      IR,
   output logic             PCout,
   output logic             ZHighout,
   output logic             Zlowout,
   output logic             MDRout,
   output logic             MARin,
   output logic             Zin,
   output logic             PCin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             HIin,
   output logic             LOin,
   output logic             IncPC,
   output logic             Read,
   output logic [4:0]       alu_op,
   output logic             reg_out_en,
   output logic [REG_W-1:0] reg_out_sel,
   output logic             reg_in_en,
   output logic [REG_W-1:0] reg_in_sel,
   output logic             Run,
   output logic             illegal
);

   // state   | meaning
   // S_RST   | held in reset, everything quiet
   // S_T0    | PC -> MAR, PC+1 -> Z
   // S_T1    | Z -> PC, memory read into MDR
   // S_T2    | MDR -> IR, opcode decided at end of cycle
   // S_T3    | Rb -> Y
   // S_T4    | Rc (Rb for neg/not) through ALU -> Z
   // S_T5    | Zlow -> Ra, or Zlow -> LO for mul/div
   // S_T6    | Zhigh -> HI (mul/div only)
   // S_PAUSE | parked between instructions while Stop is high
   // S_HALT  | halted, left only by Reset
   typedef enum logic [3:0] {
      S_RST   = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_PAUSE = 4'd8,
      S_HALT  = 4'd9
   } state_t;

   localparam logic [4:0] OPC_ADD = 5'b00011;
   localparam logic [4:0] OPC_OR  = 5'b01010;
   localparam logic [4:0] OPC_MUL = 5'b01111;
   localparam logic [4:0] OPC_DIV = 5'b10000;
   localparam logic [4:0] OPC_NEG = 5'b10001;
   localparam logic [4:0] OPC_NOT = 5'b10010;

   state_t state, state_nxt;

   logic [4:0]       opc;
   logic [REG_W-1:0] ra, rb, rc;
   logic             is_alu3, is_muldiv, is_unary, is_exec, is_halt, is_nop, is_undef;
   logic             unused_ir;

   assign opc       = IR[31:27];
   assign ra        = IR[26 -: REG_W];
   assign rb        = IR[22 -: REG_W];
   assign rc        = IR[18 -: REG_W];
   assign unused_ir = ^IR[14:0];

   assign is_alu3   = (opc >= OPC_ADD) && (opc <= OPC_OR);
   assign is_muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);
   assign is_unary  = (opc == OPC_NEG) || (opc == OPC_NOT);
   assign is_exec   = is_alu3 || is_muldiv || is_unary;
   assign is_halt   = (opc == HALT_OPC);
   assign is_nop    = (opc == NOP_OPC);
   assign is_undef  = !is_exec && !is_halt && !is_nop;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   logic set_illegal;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_RST;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_q | set_illegal;
`endif
      end
   end

`ifdef ILLEGAL_TRAP_EN
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
`ifdef ILLEGAL_TRAP_EN
      set_illegal = 1'b0;
`endif
      case (state)
         S_RST: state_nxt = S_T0;
         S_T0:  state_nxt = S_T1;
         S_T1:  state_nxt = S_T2;
         S_T2: begin
            // IR is taken as it stands in T2; undefined opcodes fall through to the NOP path
            if (is_halt) begin
               state_nxt = S_HALT;
            end else if (is_exec) begin
               state_nxt = S_T3;
`ifdef ILLEGAL_TRAP_EN
            end else if (is_undef) begin
               state_nxt   = S_HALT;
               set_illegal = 1'b1;
`endif
            end else begin
               state_nxt = Stop ? S_PAUSE : S_T0;
            end
         end
         S_T3:    state_nxt = S_T4;
         S_T4:    state_nxt = S_T5;
         S_T5:    state_nxt = is_muldiv ? S_T6 : (Stop ? S_PAUSE : S_T0);
         S_T6:    state_nxt = Stop ? S_PAUSE : S_T0;
         S_PAUSE: state_nxt = Stop ? S_PAUSE : S_T0;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_RST;
      endcase
   end

   always_comb begin
      PCout       = 1'b0;
      ZHighout    = 1'b0;
      Zlowout     = 1'b0;
      MDRout      = 1'b0;
      MARin       = 1'b0;
      Zin         = 1'b0;
      PCin        = 1'b0;
      MDRin       = 1'b0;
      IRin        = 1'b0;
      Yin         = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      IncPC       = 1'b0;
      Read        = 1'b0;
      alu_op      = 5'd0;
      reg_out_en  = 1'b0;
      reg_out_sel = '0;
      reg_in_en   = 1'b0;
      reg_in_sel  = '0;
      Run         = 1'b0;
      case (state)
         S_T0: begin
            Run   = 1'b1;
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            Run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Run         = 1'b1;
            reg_out_en  = 1'b1;
            reg_out_sel = rb;
            Yin         = 1'b1;
         end
         S_T4: begin
            Run         = 1'b1;
            reg_out_en  = 1'b1;
            reg_out_sel = is_unary ? rb : rc;
            alu_op      = opc;
            Zin         = 1'b1;
         end
         S_T5: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            if (is_muldiv) begin
               LOin = 1'b1;
            end else begin
               reg_in_en  = 1'b1;
               reg_in_sel = ra;
            end
         end
         S_T6: begin
            Run      = 1'b1;
            ZHighout = 1'b1;
            HIin     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each instruction is expanded into its expected per-cycle
// micro-step list, queued, and compared cycle by cycle by an independent monitor.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Stop  = 1'b0;
   logic [31:0] IR    = 32'd0;
   logic        PCout, ZHighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
   logic        HIin, LOin, IncPC, Read, reg_out_en, reg_in_en, Run, illegal;
   logic [4:0]  alu_op;
   logic [3:0]  reg_out_sel, reg_in_sel;

   control_sequencer dut (
      .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
      .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .alu_op(alu_op),
      .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
      .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel), .Run(Run), .illegal(illegal)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic       pc_out, zh_out, zl_out, mdr_out, mar_in, z_in, pc_in, mdr_in;
      logic       ir_in, y_in, hi_in, lo_in, inc_pc, rd;
      logic [4:0] alu;
      logic       ro_en;
      logic [3:0] ro_sel;
      logic       ri_en;
      logic [3:0] ri_sel;
      logic       run, ill;
   } vec_t;

   vec_t exp_q[$];
   vec_t prog[$];
   int   total = 0;
   int   bad   = 0;
   bit   model_ill = 1'b0;

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   // monitor: one expected vector per clock cycle while the scoreboard holds entries
   vec_t e_mon, a_mon;
   always @(negedge Clock) begin
      if (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         a_mon = '0;
         a_mon.pc_out = PCout;   a_mon.zh_out = ZHighout; a_mon.zl_out = Zlowout;
         a_mon.mdr_out = MDRout; a_mon.mar_in = MARin;    a_mon.z_in = Zin;
         a_mon.pc_in = PCin;     a_mon.mdr_in = MDRin;    a_mon.ir_in = IRin;
         a_mon.y_in = Yin;       a_mon.hi_in = HIin;      a_mon.lo_in = LOin;
         a_mon.inc_pc = IncPC;   a_mon.rd = Read;         a_mon.alu = alu_op;
         a_mon.ro_en = reg_out_en; a_mon.ro_sel = reg_out_sel;
         a_mon.ri_en = reg_in_en;  a_mon.ri_sel = reg_in_sel;
         a_mon.run = Run;        a_mon.ill = illegal;
         total++;
         if (a_mon !== e_mon) begin
            bad++;
            $display("FAIL cycle_vec t=%0t actual=%h required=%h", $time, a_mon, e_mon);
         end
      end
   end

   function automatic bit c_alu3(input logic [4:0] o);
      return (o >= 5'd3) && (o <= 5'd10);
   endfunction
   function automatic bit c_muldiv(input logic [4:0] o);
      return (o == 5'd15) || (o == 5'd16);
   endfunction
   function automatic bit c_unary(input logic [4:0] o);
      return (o == 5'd17) || (o == 5'd18);
   endfunction
   function automatic bit c_halt(input logic [4:0] o);
      return o == 5'b11001;
   endfunction
   function automatic bit c_undef(input logic [4:0] o);
      return !c_alu3(o) && !c_muldiv(o) && !c_unary(o) && !c_halt(o) && (o != 5'b11000);
   endfunction

   function automatic vec_t quiet();
      vec_t v;
      v = '0;
      v.ill = model_ill;
      return v;
   endfunction

   // instruction -> list of expected cycle vectors (fetch, then execute micro-steps)
   function automatic void expand(input logic [31:0] ir);
      logic [4:0] o;
      vec_t       b, t;
      o = ir[31:27];
      prog.delete();
      b = '0; b.run = 1'b1; b.ill = model_ill;
      t = b; t.pc_out = 1; t.mar_in = 1; t.inc_pc = 1; t.z_in = 1; prog.push_back(t);
      t = b; t.zl_out = 1; t.pc_in = 1; t.rd = 1; t.mdr_in = 1;   prog.push_back(t);
      t = b; t.mdr_out = 1; t.ir_in = 1;                          prog.push_back(t);
      if (c_alu3(o) || c_muldiv(o) || c_unary(o)) begin
         t = b; t.ro_en = 1; t.ro_sel = ir[22:19]; t.y_in = 1;   prog.push_back(t);
         t = b; t.ro_en = 1; t.ro_sel = c_unary(o) ? ir[22:19] : ir[18:15];
         t.alu = o; t.z_in = 1;                                   prog.push_back(t);
         t = b; t.zl_out = 1;
         if (c_muldiv(o)) t.lo_in = 1;
         else begin t.ri_en = 1; t.ri_sel = ir[26:23]; end
         prog.push_back(t);
         if (c_muldiv(o)) begin
            t = b; t.zh_out = 1; t.hi_in = 1;                     prog.push_back(t);
         end
      end
   endfunction

   task automatic cyc(input logic [31:0] ir, input logic stp, input logic rst, input vec_t e);
      IR = ir; Stop = stp; Reset = rst;
      exp_q.push_back(e);
      @(posedge Clock); #1;
   endtask

   task automatic run_instr(input logic [31:0] ir, input int pause_len, input int reset_at,
                            input int stop_from, input int halt_len);
      logic [4:0] o;
      bit         halts;
      logic       stp;
      int         n;
      o = ir[31:27];
      halts = c_halt(o) || (TRAP && c_undef(o));
      expand(ir);
      n = prog.size();
      for (int i = 0; i < n; i++) begin
         stp = 1'($urandom_range(0, 1));
         if (stop_from >= 0 && i >= stop_from) stp = 1'b1;
         if (!halts && i == n - 1) stp = (pause_len > 0);
         if (i == reset_at) begin
            cyc(ir, stp, 1'b1, prog[i]);
            model_ill = 1'b0;
            cyc($urandom, 1'($urandom_range(0, 1)), 1'b0, quiet());
            return;
         end
         cyc(ir, stp, 1'b0, prog[i]);
      end
      if (halts) begin
         if (c_undef(o)) model_ill = 1'b1;
         for (int k = 0; k < halt_len; k++)
            cyc($urandom, 1'($urandom_range(0, 1)), 1'b0, quiet());
         cyc($urandom, 1'($urandom_range(0, 1)), 1'b1, quiet());
         model_ill = 1'b0;
         cyc($urandom, 1'($urandom_range(0, 1)), 1'b0, quiet());
      end else begin
         for (int k = 0; k < pause_len; k++)
            cyc(ir, (k < pause_len - 1), 1'b0, quiet());
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] o, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
      return {o, a, b, c, 15'($urandom)};
   endfunction

   logic [4:0] opc_list [12] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                 5'd15, 5'd16, 5'd17, 5'd18};

   initial begin
      logic [4:0] ro;
      Reset = 1'b1;
      @(posedge Clock); #1;
      cyc(32'd0, 1'b0, 1'b1, quiet());
      cyc(32'd0, 1'b0, 1'b0, quiet());

      run_instr(32'h4A920000, 0, -1, -1, 0);                    // and R5,R2,R4
      run_instr(mk(5'b01111, 4'd1, 4'd3, 4'd6), 0, -1, -1, 0);  // mul Rb=3 Rc=6
      run_instr(mk(5'b11000, 4'd0, 4'd0, 4'd0), 0, -1, -1, 0);  // nop
      run_instr(mk(5'b00011, 4'd7, 4'd8, 4'd9), 2, -1, 3, 0);   // add, Stop from T3
      run_instr(mk(5'b00100, 4'd1, 4'd2, 4'd3), 0, 4, -1, 0);   // sub, reset in T4
      run_instr(mk(5'b11111, 4'd2, 4'd2, 4'd2), 0, -1, -1, 4);  // undefined
      run_instr(mk(5'b11001, 4'd0, 4'd0, 4'd0), 0, -1, -1, 10); // halt
      run_instr(mk(5'b10001, 4'd6, 4'd11, 4'd12), 1, -1, -1, 0);// neg uses Rb in T4
      run_instr(mk(5'b10000, 4'd9, 4'd14, 4'd15), 3, -1, -1, 0);// div then pause

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) ro = 5'($urandom_range(0, 31));
         else ro = opc_list[$urandom_range(0, 11)];
         run_instr(mk(ro, 4'($urandom), 4'($urandom), 4'($urandom)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1,
                   -1, int'($urandom_range(1, 5)));
      end

      repeat (2) @(negedge Clock);
      @(posedge Clock);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
